ssd1306_spi_receiver: RTL

SSD1306_SPI_RECEIVER -- requirements
Module: ssd1306_spi_receiver

---
 rtl/ssd1306_pkg.sv | 39 +++
 rtl/ssd1306_spi_receiver_byte_rx.sv | 92 +++++++++
 rtl/ssd1306_spi_receiver.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/ssd1306_pkg.sv
// Shared constants for the SSD1306 SPI receiver: opcodes, addressing modes,
// decoder states and the opcode parameter-count lookup.
package ssd1306_pkg;

    localparam logic [7:0] OP_DISPLAY_OFF = 8'hAE;
    localparam logic [7:0] OP_DISPLAY_ON  = 8'hAF;
    localparam logic [7:0] OP_CONTRAST    = 8'h81;
    localparam logic [7:0] OP_ADDR_MODE   = 8'h20;
    localparam logic [7:0] OP_COL_ADDR    = 8'h21;
    localparam logic [7:0] OP_PAGE_ADDR   = 8'h22;
    localparam logic [7:0] OP_MUX_RATIO   = 8'hA8;
    localparam logic [7:0] OP_DISP_OFFSET = 8'hD3;
    localparam logic [7:0] OP_CLK_DIV     = 8'hD5;
    localparam logic [7:0] OP_PRECHARGE   = 8'hD9;
    localparam logic [7:0] OP_VCOMH       = 8'hDB;
    localparam logic [7:0] OP_CHARGE_PUMP = 8'h8D;

    localparam logic [1:0] MODE_HORIZONTAL = 2'd0;
    localparam logic [1:0] MODE_VERTICAL   = 2'd1;
    localparam logic [1:0] MODE_PAGE       = 2'd2;

    localparam logic [7:0] CONTRAST_RESET = 8'h7F;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PARAM1 = 2'd1,
        PARAM2 = 2'd2
    } dec_state_e;

    function automatic logic [1:0] param_count(input logic [7:0] opcode);
        case (opcode)
            OP_CONTRAST, OP_ADDR_MODE, OP_MUX_RATIO, OP_DISP_OFFSET,
            OP_CLK_DIV, OP_PRECHARGE, OP_VCOMH, OP_CHARGE_PUMP: param_count = 2'd1;
            OP_COL_ADDR, OP_PAGE_ADDR:                          param_count = 2'd2;
            default:                                            param_count = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/ssd1306_spi_receiver_byte_rx.sv
// Synchronizes the io_* pins, detects SCLK/CS edges and assembles SPI bytes MSB first.
// Outputs are combinational from registered state and valid in the edge-detect cycle.
module spi_byte_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       io_sclk,
    input  logic       io_sdin,
    input  logic       io_cs,
    input  logic       io_dc,
    input  logic       io_reset,
    output logic       disp_rst_n,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_dc,
    output logic       byte_err
);

    // Bit order {reset, dc, cs, sdin, sclk}; idle levels keep the link quiet after reset.
    localparam logic [4:0] SYNC_RESET = 5'b10100;

    logic [4:0] sync_q [SYNC_STAGES];
    logic [4:0] sync_d [SYNC_STAGES];
    logic       sclk_prev_q, sclk_prev_d;
    logic       cs_prev_q, cs_prev_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] shift_q, shift_d;

    logic s_sclk, s_sdin, s_cs, s_dc, s_reset;
    logic sclk_rise, cs_rise;

    assign s_sclk  = sync_q[SYNC_STAGES-1][0];
    assign s_sdin  = sync_q[SYNC_STAGES-1][1];
    assign s_cs    = sync_q[SYNC_STAGES-1][2];
    assign s_dc    = sync_q[SYNC_STAGES-1][3];
    assign s_reset = sync_q[SYNC_STAGES-1][4];

    assign disp_rst_n = s_reset;

    always_comb begin
        sync_d[0] = {io_reset, io_dc, io_cs, io_sdin, io_sclk};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_comb begin
        sclk_prev_d = s_sclk;
        cs_prev_d   = s_cs;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        sclk_rise   = s_sclk & ~sclk_prev_q;
        cs_rise     = s_cs & ~cs_prev_q;
        byte_valid  = 1'b0;
        byte_err    = 1'b0;
        byte_data   = {shift_q, s_sdin};
        byte_dc     = s_dc;

        // A held display reset clears the counter, so a partial byte dies silently.
        if (!s_reset) begin
            bit_cnt_d = 3'd0;
            shift_d   = 7'd0;
        end else if (s_cs) begin
            bit_cnt_d = 3'd0;
            byte_err  = cs_rise && (bit_cnt_q != 3'd0);
        end else if (sclk_rise) begin
            shift_d    = {shift_q[5:0], s_sdin};
            bit_cnt_d  = bit_cnt_q + 3'd1;
            byte_valid = (bit_cnt_q == 3'd7);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= SYNC_RESET;
            end
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 7'd0;
        end else begin
            sync_q      <= sync_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
        end
    end

endmodule

// File: rtl/ssd1306_spi_receiver.sv
// SSD1306 SPI slave: decodes commands into configuration state and turns data bytes
// into framebuffer writes. Define SSD1306_RX_FRAME_CNT_EN to add the frame_count output.
module ssd1306_spi_receiver
    import ssd1306_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        io_sclk,
    input  logic        io_sdin,
    input  logic        io_cs,
    input  logic        io_dc,
    input  logic        io_reset,
    output logic        fb_we,
    output logic [9:0]  fb_addr,
    output logic [7:0]  fb_wdata,
    output logic        display_on,
    output logic [7:0]  contrast,
    output logic [1:0]  addr_mode,
`ifdef SSD1306_RX_FRAME_CNT_EN
    output logic [15:0] frame_count,
`endif
    output logic        byte_err
);

    logic       disp_rst_n, rx_valid, rx_dc, rx_err;
    logic [7:0] rx_data;

    spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .io_sclk    (io_sclk),
        .io_sdin    (io_sdin),
        .io_cs      (io_cs),
        .io_dc      (io_dc),
        .io_reset   (io_reset),
        .disp_rst_n (disp_rst_n),
        .byte_valid (rx_valid),
        .byte_data  (rx_data),
        .byte_dc    (rx_dc),
        .byte_err   (rx_err)
    );

    dec_state_e state_q, state_d;
    logic [7:0] opcode_q, opcode_d;
    logic       display_on_q, display_on_d;
    logic [7:0] contrast_q, contrast_d;
    logic [1:0] addr_mode_q, addr_mode_d;
    logic [6:0] col_start_q, col_start_d, col_end_q, col_end_d, col_q, col_d;
    logic [2:0] page_start_q, page_start_d, page_end_q, page_end_d, page_q, page_d;
    logic       fb_we_q, fb_we_d;
    logic [9:0] fb_addr_q, fb_addr_d;
    logic [7:0] fb_wdata_q, fb_wdata_d;
    logic       byte_err_q, byte_err_d;
    logic       col_at_end, page_at_end;
`ifdef SSD1306_RX_FRAME_CNT_EN
    logic [15:0] frame_count_q, frame_count_d;
`endif

    always_comb begin
        state_d      = state_q;
        opcode_d     = opcode_q;
        display_on_d = display_on_q;
        contrast_d   = contrast_q;
        addr_mode_d  = addr_mode_q;
        col_start_d  = col_start_q;
        col_end_d    = col_end_q;
        page_start_d = page_start_q;
        page_end_d   = page_end_q;
        col_d        = col_q;
        page_d       = page_q;
        fb_we_d      = 1'b0;
        fb_addr_d    = fb_addr_q;
        fb_wdata_d   = fb_wdata_q;
        byte_err_d   = rx_err;
        col_at_end   = (col_q == col_end_q);
        page_at_end  = (page_q == page_end_q);
`ifdef SSD1306_RX_FRAME_CNT_EN
        frame_count_d = frame_count_q;
`endif

        if (rx_valid && rx_dc) begin
            state_d    = IDLE;
            fb_we_d    = 1'b1;
            fb_addr_d  = {page_q, col_q};
            fb_wdata_d = rx_data;
            // Only vertical mode walks pages first; every other mode behaves horizontally.
            if (addr_mode_q == MODE_VERTICAL) begin
                if (page_at_end) begin
                    page_d = page_start_q;
                    col_d  = col_at_end ? col_start_q : col_q + 7'd1;
                end else begin
                    page_d = page_q + 3'd1;
                end
            end else begin
                if (col_at_end) begin
                    col_d  = col_start_q;
                    page_d = page_at_end ? page_start_q : page_q + 3'd1;
                end else begin
                    col_d = col_q + 7'd1;
                end
            end
`ifdef SSD1306_RX_FRAME_CNT_EN
            if (col_at_end && page_at_end) begin
                frame_count_d = frame_count_q + 16'd1;
            end
`endif
        end else if (rx_valid) begin
            case (state_q)
                IDLE: begin
                    opcode_d = rx_data;
                    if (param_count(rx_data) != 2'd0) begin
                        state_d = PARAM1;
                    end else if (rx_data == OP_DISPLAY_OFF) begin
                        display_on_d = 1'b0;
                    end else if (rx_data == OP_DISPLAY_ON) begin
                        display_on_d = 1'b1;
                    end
                end
                PARAM1: begin
                    case (opcode_q)
                        OP_CONTRAST:  contrast_d   = rx_data;
                        OP_ADDR_MODE: addr_mode_d  = (rx_data[1:0] == MODE_PAGE) ? MODE_HORIZONTAL : rx_data[1:0];
                        OP_COL_ADDR:  col_start_d  = rx_data[6:0];
                        OP_PAGE_ADDR: page_start_d = rx_data[2:0];
                        default: ;
                    endcase
                    state_d = (param_count(opcode_q) == 2'd2) ? PARAM2 : IDLE;
                end
                PARAM2: begin
                    if (opcode_q == OP_COL_ADDR) begin
                        col_end_d = rx_data[6:0];
                        col_d     = col_start_q;
                    end else if (opcode_q == OP_PAGE_ADDR) begin
                        page_end_d = rx_data[2:0];
                        page_d     = page_start_q;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        if (!disp_rst_n) begin
            state_d      = IDLE;
            opcode_d     = 8'd0;
            display_on_d = 1'b0;
            contrast_d   = CONTRAST_RESET;
            addr_mode_d  = MODE_HORIZONTAL;
            col_start_d  = 7'd0;
            col_end_d    = 7'd127;
            page_start_d = 3'd0;
            page_end_d   = 3'd7;
            col_d        = 7'd0;
            page_d       = 3'd0;
            fb_we_d      = 1'b0;
            fb_addr_d    = 10'd0;
            fb_wdata_d   = 8'd0;
            byte_err_d   = 1'b0;
`ifdef SSD1306_RX_FRAME_CNT_EN
            frame_count_d = 16'd0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            opcode_q     <= 8'd0;
            display_on_q <= 1'b0;
            contrast_q   <= CONTRAST_RESET;
            addr_mode_q  <= MODE_HORIZONTAL;
            col_start_q  <= 7'd0;
            col_end_q    <= 7'd127;
            page_start_q <= 3'd0;
            page_end_q   <= 3'd7;
            col_q        <= 7'd0;
            page_q       <= 3'd0;
            fb_we_q      <= 1'b0;
            fb_addr_q    <= 10'd0;
            fb_wdata_q   <= 8'd0;
            byte_err_q   <= 1'b0;
`ifdef SSD1306_RX_FRAME_CNT_EN
            frame_count_q <= 16'd0;
`endif
        end else begin
            state_q      <= state_d;
            opcode_q     <= opcode_d;
            display_on_q <= display_on_d;
            contrast_q   <= contrast_d;
            addr_mode_q  <= addr_mode_d;
            col_start_q  <= col_start_d;
            col_end_q    <= col_end_d;
            page_start_q <= page_start_d;
            page_end_q   <= page_end_d;
            col_q        <= col_d;
            page_q       <= page_d;
            fb_we_q      <= fb_we_d;
            fb_addr_q    <= fb_addr_d;
            fb_wdata_q   <= fb_wdata_d;
            byte_err_q   <= byte_err_d;
`ifdef SSD1306_RX_FRAME_CNT_EN
            frame_count_q <= frame_count_d;
`endif
        end
    end

    assign fb_we      = fb_we_q;
    assign fb_addr    = fb_addr_q;
    assign fb_wdata   = fb_wdata_q;
    assign display_on = display_on_q;
    assign contrast   = contrast_q;
    assign addr_mode  = addr_mode_q;
    assign byte_err   = byte_err_q;
`ifdef SSD1306_RX_FRAME_CNT_EN
    assign frame_count = frame_count_q;
`endif

endmodule
